// File: rtl/regfile_write_arbiter_if.sv
// Purpose: groups the two writeback request channels and the register-file
//          write port of regfile_write_arbiter into one bundle.
// Signals:
//   req0_* : ALU writeback channel (valid/rd/data in, ready out)
//   req1_* : load / multicycle writeback channel (valid/rd/data in, ready out)
//   write_enable/write_port/write_data : register-file write port
//   starved : requester 1 has reached its blocked-cycle limit
// Modports: slave = arbiter side, master = requester/register-file side.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_rd;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_rd;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_port;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  starved;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output write_enable, write_port, write_data,
    output starved
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  write_enable, write_port, write_data,
    input  starved
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register file's single write port between the ALU
//          writeback path (requester 0) and the load/multicycle path
//          (requester 1). Winning writes are registered and presented to the
//          register file one cycle after the transfer. Writes to x0 are
//          accepted and dropped without using the port; a saturating
//          starvation counter lets requester 1 win after STARVE_LIMIT
//          consecutive blocked cycles.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : regfile_write_arbiter_if.slave (request channels, write port,
//           starved flag)
// Parameters: DATA_WIDTH, ADDR_WIDTH, STARVE_LIMIT (legal range >= 1).
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  regfile_write_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      cnt_q,  cnt_d;
  logic                  we_q,   we_d;
  logic [ADDR_WIDTH-1:0] port_q, port_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic need0, need1;
  logic x0_0, x0_1;
  logic starved_c;
  logic grant0_c, grant1_c;
  logic ready0_c, ready1_c;

  // Arbitration: port demand, grant and ready generation.
  always_comb begin
    need0     = 1'b0;
    need1     = 1'b0;
    x0_0      = 1'b0;
    x0_1      = 1'b0;
    grant0_c  = 1'b0;
    grant1_c  = 1'b0;
    ready0_c  = 1'b0;
    ready1_c  = 1'b0;
    starved_c = (cnt_q == LIMIT);

    x0_0  = bus.req0_valid && (bus.req0_rd == '0);
    x0_1  = bus.req1_valid && (bus.req1_rd == '0);
    need0 = bus.req0_valid && (bus.req0_rd != '0);
    need1 = bus.req1_valid && (bus.req1_rd != '0);

    // Requester 1 wins when the ALU path is idle or it has been starved.
    if (!reset) begin
      grant1_c = need1 && (!need0 || starved_c);
      grant0_c = need0 && !grant1_c;
      ready0_c = grant0_c || x0_0;
      ready1_c = grant1_c || x0_1;
    end
  end

  // Next-state: starvation counter and staged write.
  always_comb begin
    cnt_d  = '0;
    we_d   = 1'b0;
    port_d = port_q;
    data_d = data_q;

    // A blocked requester 1 saturates at LIMIT; any transfer or idle clears.
    if (need1 && !ready1_c) begin
      if (cnt_q == LIMIT) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
      end
    end

    if (grant1_c) begin
      we_d   = 1'b1;
      port_d = bus.req1_rd;
      data_d = bus.req1_data;
    end else if (grant0_c) begin
      we_d   = 1'b1;
      port_d = bus.req0_rd;
      data_d = bus.req0_data;
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      we_q   <= 1'b0;
      port_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      port_q <= port_d;
      data_q <= data_d;
    end
  end

  // A reset arriving while a write is staged suppresses that write.
  assign bus.write_enable = we_q && !reset;
  assign bus.write_port   = port_q;
  assign bus.write_data   = data_q;
  assign bus.starved      = starved_c;
  assign bus.req0_ready   = ready0_c;
  assign bus.req1_ready   = ready1_c;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LIM = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Behavioural model state
  int          cnt_m;
  bit          pend_we;
  logic [AW-1:0] pend_port;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] model_rf [32];
  logic [DW-1:0] dut_rf   [32];

  // Per-cycle decisions of the model
  bit            cur_rst, cur_n1, g0, g1, r0e, r1e;
  logic [AW-1:0] cur_rd0, cur_rd1;
  logic [DW-1:0] cur_d0, cur_d1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, form model expectations, optionally compare.
  task automatic drive(input bit rst,
                       input bit v0, input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                       input bit v1, input logic [AW-1:0] rd1, input logic [DW-1:0] d1,
                       input bit do_chk);
    bit st_m, n0, n1;
    reset          = rst;
    bus.req0_valid = v0; bus.req0_rd = rd0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_rd = rd1; bus.req1_data = d1;
    #3;
    st_m = (cnt_m == LIM);
    n0   = v0 && (rd0 != 0);
    n1   = v1 && (rd1 != 0);
    g1   = !rst && n1 && (!n0 || st_m);
    g0   = !rst && n0 && !g1;
    r0e  = !rst && v0 && ((rd0 == 0) || g0);
    r1e  = !rst && v1 && ((rd1 == 0) || g1);
    cur_rst = rst; cur_n1 = n1;
    cur_rd0 = rd0; cur_d0 = d0; cur_rd1 = rd1; cur_d1 = d1;
    if (do_chk) begin
      chk("req0_ready",   64'(bus.req0_ready),   64'(r0e));
      chk("req1_ready",   64'(bus.req1_ready),   64'(r1e));
      chk("write_enable", 64'(bus.write_enable), 64'(pend_we && !rst));
      chk("write_port",   64'(bus.write_port),   64'(pend_port));
      chk("write_data",   64'(bus.write_data),   64'(pend_data));
      chk("starved",      64'(bus.starved),      64'(st_m));
    end
  endtask

  // Commit this cycle in the model and the shadow register file, then advance.
  task automatic tick();
    if (bus.write_enable === 1'b1) dut_rf[bus.write_port] = bus.write_data;
    if (pend_we && !cur_rst) model_rf[pend_port] = pend_data;
    if (cur_rst) begin
      pend_we = 0; pend_port = '0; pend_data = '0; cnt_m = 0;
    end else begin
      pend_we = g0 || g1;
      if (g1) begin
        pend_port = cur_rd1; pend_data = cur_d1;
      end else if (g0) begin
        pend_port = cur_rd0; pend_data = cur_d0;
      end
      if (cur_n1 && !r1e) cnt_m = (cnt_m < LIM) ? cnt_m + 1 : LIM;
      else                cnt_m = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit do_chk);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, do_chk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            v0, v1, rst;
    logic [AW-1:0] rd0, rd1;
    logic [DW-1:0] d0, d1;

    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
    cnt_m = 0; pend_we = 0; pend_port = '0; pend_data = '0;
    reset = 1'b1;
    bus.req0_valid = 0; bus.req0_rd = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_rd = '0; bus.req1_data = '0;
    @(posedge clock);
    #1;

    // Reset: outputs at reset values, no ready even with live requests
    drive(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1);
    chk("reset_ready0", 64'(bus.req0_ready), 64'(0));
    chk("reset_ready1", 64'(bus.req1_ready), 64'(0));
    tick();

    // Single write on requester 0
    drive(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1);
    chk("single0_ready", 64'(bus.req0_ready), 64'(1));
    tick();
    idle(1'b1);
    chk("single0_we",   64'(bus.write_enable), 64'(1));
    chk("single0_port", 64'(bus.write_port),   64'(3));
    chk("single0_data", 64'(bus.write_data),   64'h0000_0000_DEAD_BEEF);
    tick();
    idle(1'b1);
    chk("single0_we_off", 64'(bus.write_enable), 64'(0));
    tick();

    // Single write on requester 1
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd31, 32'h1, 1'b1);
    chk("single1_ready", 64'(bus.req1_ready), 64'(1));
    tick();
    idle(1'b1);
    chk("single1_port", 64'(bus.write_port), 64'(31));
    chk("single1_data", 64'(bus.write_data), 64'(1));
    tick();

    // Conflict: requester 0 first, requester 1 next cycle
    drive(1'b0, 1'b1, 5'd5, 32'hA, 1'b1, 5'd6, 32'hB, 1'b1);
    chk("conf_ready0", 64'(bus.req0_ready), 64'(1));
    chk("conf_ready1", 64'(bus.req1_ready), 64'(0));
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd6, 32'hB, 1'b1);
    chk("conf_port_a",  64'(bus.write_port), 64'(5));
    chk("conf_ready1b", 64'(bus.req1_ready), 64'(1));
    tick();
    idle(1'b1);
    chk("conf_port_b", 64'(bus.write_port), 64'(6));
    chk("conf_data_b", 64'(bus.write_data), 64'hB);
    tick();

    // Starvation: requester 1 blocked cycles 1..4, wins cycle 5
    for (int c = 1; c <= 6; c++) begin
      drive(1'b0, 1'b1, 5'd1, DW'(c), (c <= 5), 5'd2, 32'h22, 1'b1);
      if (c <= 4) chk("starve_blocked", 64'(bus.req1_ready), 64'(0));
      if (c == 5) begin
        chk("starve_flag",   64'(bus.starved),    64'(1));
        chk("starve_ready1", 64'(bus.req1_ready), 64'(1));
        chk("starve_ready0", 64'(bus.req0_ready), 64'(0));
      end
      if (c == 6) begin
        chk("starve_port",   64'(bus.write_port), 64'(2));
        chk("starve_clear",  64'(bus.starved),    64'(0));
        chk("starve_resume", 64'(bus.req0_ready), 64'(1));
      end
      tick();
    end
    idle(1'b1);
    tick();

    // x0 absorption
    drive(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd7, 32'h77, 1'b1);
    chk("x0_ready0", 64'(bus.req0_ready), 64'(1));
    chk("x0_ready1", 64'(bus.req1_ready), 64'(1));
    tick();
    drive(1'b0, 1'b1, 5'd0, 32'h66, 1'b1, 5'd0, 32'h99, 1'b1);
    chk("x0_one_port", 64'(bus.write_port), 64'(7));
    chk("x0_both_rdy", 64'({bus.req0_ready, bus.req1_ready}), 64'(3));
    tick();
    idle(1'b1);
    chk("x0_no_write", 64'(bus.write_enable), 64'(0));
    tick();

    // Same destination from both requesters
    drive(1'b0, 1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22, 1'b1);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h22, 1'b1);
    chk("same_rd_first", 64'(bus.write_data), 64'h11);
    tick();
    idle(1'b1);
    chk("same_rd_second", 64'(bus.write_data), 64'h22);
    tick();
    idle(1'b1);
    tick();
    chk("same_rd_readback", 64'(dut_rf[9]), 64'h22);

    // Reset in the cycle after an accepted write
    drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, '0, '0, 1'b1);
    chk("rst_accept", 64'(bus.req0_ready), 64'(1));
    tick();
    drive(1'b1, 1'b1, 5'd4, 32'h45, 1'b1, 5'd5, 32'h46, 1'b1);
    chk("rst_drop_we", 64'(bus.write_enable), 64'(0));
    chk("rst_ready0",  64'(bus.req0_ready),   64'(0));
    chk("rst_ready1",  64'(bus.req1_ready),   64'(0));
    tick();
    idle(1'b1);
    chk("rst_we_after", 64'(bus.write_enable), 64'(0));
    tick();
    drive(1'b0, 1'b1, 5'd8, 32'h88, 1'b0, '0, '0, 1'b1);
    chk("rst_resume", 64'(bus.req0_ready), 64'(1));
    tick();
    idle(1'b1);
    chk("rst_resume_port", 64'(bus.write_port), 64'(8));
    tick();

    // Randomized traffic; a requester holds rd/data while not accepted
    v0 = 0; v1 = 0; rd0 = '0; rd1 = '0; d0 = '0; d1 = '0; r0e = 0; r1e = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(v0 && !r0e)) begin
        v0  = ($urandom_range(0, 3) != 0);
        rd0 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        d0  = DW'($urandom);
      end
      if (!(v1 && !r1e)) begin
        v1  = ($urandom_range(0, 2) != 0);
        rd1 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        d1  = DW'($urandom);
      end
      rst = ($urandom_range(0, 39) == 0);
      drive(rst, v0, rd0, d0, v1, rd1, d1, 1'b1);
      tick();
    end
    idle(1'b1);
    tick();
    idle(1'b1);
    tick();

    for (int i = 1; i < 32; i++) begin
      chk($sformatf("rf_x%0d", i), 64'(dut_rf[i]), 64'(model_rf[i]));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters. Requester 0 is the single-cycle ALU result path; requester 1 is the long-latency load / multicycle result path. The block arbitrates each cycle, registers the winning write, and drives the register file's `write_enable` / `write_port` / `write_data` one cycle later. Writes to x0 are absorbed without consuming the port, and a starvation counter stops requester 1 from being locked out by back-to-back ALU writes.

## Interface
Parameters:
- `DATA_WIDTH`, 32: write data width.
- `ADDR_WIDTH`, 5: register index width.
- `STARVE_LIMIT`, 4: consecutive blocked cycles of requester 1 before it takes priority. Legal range ≥1.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: ALU writeback request.
- `req0_rd` in `ADDR_WIDTH`: destination register.
- `req0_data` in `DATA_WIDTH`: result.
- `req0_ready` out 1: combinational accept for requester 0.
- `req1_valid`, `req1_rd`, `req1_data`, `req1_ready`: same as requester 0, for the load/multicycle path.
- `write_enable` out 1: to register file, registered.
- `write_port` out `ADDR_WIDTH`: to register file, registered.
- `write_data` out `DATA_WIDTH`: to register file, registered.
- `starved` out 1: high while the starvation counter equals `STARVE_LIMIT`.

## Operation
- Handshake: a transfer occurs in a cycle where `valid && ready`. While `valid && !ready`, the requester holds `rd` and `data` stable. `ready` never depends on `ready` of the same port.
- Port demand: `need0 = req0_valid && req0_rd != 0`; `need1 = req1_valid && req1_rd != 0`.
- x0 requests (`valid` with `rd == 0`):
  - `ready = 1` unconditionally; the request is accepted and discarded.
  - No write is issued.
  - Does not block the other requester, so both ports may be ready in the same cycle.
- Grant rules:
  - Only `need0` → grant 0.
  - Only `need1` → grant 1.
  - Both, with `starved == 0` → grant 0; `req1_ready = 0`.
  - Both, with `starved == 1` → grant 1; `req0_ready = 0`.
  - `reqN_ready = 1` when granted or x0; otherwise 0.
- Starvation counter `cnt`, width `$clog2(STARVE_LIMIT+1)`:
  - `need1 && !req1_ready` → `cnt = min(cnt+1, STARVE_LIMIT)` (saturating).
  - Requester 1 transfer, or `!req1_valid` → `cnt = 0`.
  - `starved = (cnt == STARVE_LIMIT)`.
- Output stage:
  - On a grant: `write_enable <= 1`, `write_port <= granted rd`, `write_data <= granted data`.
  - Otherwise: `write_enable <= 0`; `write_port` and `write_data` hold their previous values.
- Same `rd` from both requesters in one cycle: ordinary conflict resolved by the grant rules. The loser writes in a later cycle, so the last register value is the later-granted one.
- No backpressure from the register file; one write per cycle maximum.

## Timing
- Reset values: `write_enable = 0`, `write_port = 0`, `write_data = 0`, `cnt = 0`, `starved = 0`.
- During reset, `req0_ready = req1_ready = 0`, so no transfer is accepted in a reset cycle.
- Reset asserted mid-operation drops the write staged for the next cycle (`write_enable` low the cycle after reset) and clears `cnt`.
- Latency for a transfer in cycle N:
  - `write_enable` high in cycle N+1.
  - Register file updates at the end of cycle N+1.
  - Read ports return the new value from cycle N+2.
- Throughput: one port write per cycle. Continuous `need0` with `need1` gives requester 1 a grant no later than its `STARVE_LIMIT+1`-th blocked cycle.
- After a starvation grant, `cnt` is 0, so requester 0 regains priority on the next cycle.

## Test plan
- Single writes: `req0` rd=3 data=0xDEADBEEF in cycle 1 → `req0_ready=1`. Cycle 2: `write_enable=1`, `write_port=3`, `write_data=0xDEADBEEF`. Cycle 3: `write_enable=0`. Repeat on `req1` rd=31 data=0x1.
- Conflict: both valid in cycle 1, rd0=5 data=0xA, rd1=6 data=0xB → cycle 1 `req0_ready=1`, `req1_ready=0`. Cycle 2 writes 5/0xA and accepts `req1`. Cycle 3 writes 6/0xB.
- Starvation with `STARVE_LIMIT=4`: `req0` valid every cycle to rd=1, `req1` held valid rd=2 from cycle 1 → `req1` blocked cycles 1–4. Cycle 5: `starved=1`, `req1_ready=1`, `req0_ready=0`. Cycle 6: writes rd=2, `starved=0`, `req0` accepted again.
- x0 absorption: `req0` rd=0 and `req1` rd=7 both valid → both ready in the same cycle; exactly one write (rd=7) next cycle. Both requesters with rd=0 → both ready, no `write_enable`.
- Same-rd conflict: both target rd=9, data0=0x11, data1=0x22 → writes in order 0x11 then 0x22; a read of x9 after completion returns 0x22.
- Reset mid-operation: accept a `req0` write in cycle N, assert `reset` in cycle N+1 → `write_enable=0` in N+1 and N+2, `cnt=0`, all readies low during reset; normal grants resume the cycle after `reset` deasserts.
